// File: rtl/axi4_burst_slave_mem.sv
// AXI4 slave memory model: independent read and write burst engines
// (FIXED / INCR / WRAP) over a byte-laned memory, with SLVERR reporting
// for illegal burst parameters, out-of-range words and wlast mismatches.
module axi4_burst_slave_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_awvalid,
    output logic                    s_awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic                    m_wvalid,
    output logic                    s_wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    s_bvalid,
    input  logic                    m_bready,
    output logic [1:0]              bresp,
    output logic [ID_WIDTH-1:0]     bid,
    input  logic                    m_arvalid,
    output logic                    s_arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic [ID_WIDTH-1:0]     arid,
    output logic                    s_rvalid,
    input  logic                    m_rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic [ID_WIDTH-1:0]     rid
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [2:0]            MAX_SIZE = 3'(SHIFT);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Burst parameters that make every beat of the burst illegal.
    function automatic logic params_bad(input logic [7:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > MAX_SIZE) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> SHIFT) >= DEPTH_A;
    endfunction

    // Address of the following beat; WRAP keeps the offset inside the aligned window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                         input logic [7:0] len,
                                                         input logic [2:0] size,
                                                         input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
            default: next_addr = addr + step;
        endcase
    endfunction

    // ---------------- write channel state ----------------
    logic [1:0]            w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            w_size_q, w_size_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic                  w_err_q, w_err_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  s_awready_q, s_wready_q, s_bvalid_q;
    logic                  w_fire, w_beat_last, w_beat_err, w_do_write;
    logic [IDX_W-1:0]      w_idx;

    assign w_fire      = m_wvalid && s_wready_q;
    assign w_beat_last = (w_cnt_q == w_len_q);
    assign w_beat_err  = params_bad(w_len_q, w_size_q, w_burst_q) || addr_oor(w_addr_q)
                         || (wlast != w_beat_last);
    // Once a burst is known to be bad, its remaining beats are discarded too.
    assign w_do_write  = w_fire && !w_beat_err && !w_err_q;
    assign w_idx       = w_addr_q[SHIFT +: IDX_W];

    // Write FSM next state: capture AW, step beats, hold response until accepted.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        bid_d     = bid_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (m_awvalid && s_awready_q) begin
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    bid_d     = awid;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    w_err_d  = w_err_q || w_beat_err;
                    w_cnt_d  = w_cnt_q + 8'd1;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    if (w_beat_last) begin
                        bresp_d   = (w_err_q || w_beat_err) ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (m_bready && s_bvalid_q) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers; handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            w_addr_q    <= '0;
            w_len_q     <= '0;
            w_size_q    <= '0;
            w_burst_q   <= '0;
            bid_q       <= '0;
            w_cnt_q     <= '0;
            w_err_q     <= 1'b0;
            bresp_q     <= 2'b00;
            s_awready_q <= 1'b0;
            s_wready_q  <= 1'b0;
            s_bvalid_q  <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            w_addr_q    <= w_addr_d;
            w_len_q     <= w_len_d;
            w_size_q    <= w_size_d;
            w_burst_q   <= w_burst_d;
            bid_q       <= bid_d;
            w_cnt_q     <= w_cnt_d;
            w_err_q     <= w_err_d;
            bresp_q     <= bresp_d;
            s_awready_q <= (w_state_d == W_IDLE);
            s_wready_q  <= (w_state_d == W_DATA);
            s_bvalid_q  <= (w_state_d == W_RESP);
        end
    end

    // ---------------- read channel state ----------------
    logic [0:0]            r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic                  s_arready_q, s_rvalid_q;
    logic                  r_fire, r_beat_err;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign r_fire     = s_rvalid_q && m_rready;
    assign r_beat_err = params_bad(r_len_q, r_size_q, r_burst_q) || addr_oor(r_addr_q);
    assign r_idx      = r_addr_q[SHIFT +: IDX_W];

    // Read FSM next state: capture AR, advance on every accepted beat.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        rid_d     = rid_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (m_arvalid && s_arready_q) begin
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = arburst;
                    rid_d     = arid;
                    r_cnt_d   = 8'd0;
                    r_state_d = R_DATA;
                end
            end
            default: begin
                if (r_fire) begin
                    r_cnt_d  = r_cnt_q + 8'd1;
                    r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            r_addr_q    <= '0;
            r_len_q     <= '0;
            r_size_q    <= '0;
            r_burst_q   <= '0;
            rid_q       <= '0;
            r_cnt_q     <= '0;
            s_arready_q <= 1'b0;
            s_rvalid_q  <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            r_addr_q    <= r_addr_d;
            r_len_q     <= r_len_d;
            r_size_q    <= r_size_d;
            r_burst_q   <= r_burst_d;
            rid_q       <= rid_d;
            r_cnt_q     <= r_cnt_d;
            s_arready_q <= (r_state_d == R_IDLE);
            s_rvalid_q  <= (r_state_d == R_DATA);
        end
    end

    // ---------------- storage: one byte-wide array per lane ----------------
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_DEPTH];

        // Strobed byte write; contents deliberately survive reset.
        always_ff @(posedge clk) begin
            if (w_do_write && wstrb[gi]) begin
                lane_mem[w_idx] <= wdata[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = lane_mem[r_idx];
    end

    assign s_awready = s_awready_q;
    assign s_wready  = s_wready_q;
    assign s_bvalid  = s_bvalid_q;
    assign bresp     = bresp_q;
    assign bid       = bid_q;
    assign s_arready = s_arready_q;
    assign s_rvalid  = s_rvalid_q;
    assign rdata     = (s_rvalid_q && !r_beat_err) ? rd_word : '0;
    assign rresp     = (s_rvalid_q && r_beat_err) ? 2'b10 : 2'b00;
    assign rlast     = s_rvalid_q && (r_cnt_q == r_len_q);
    assign rid       = rid_q;

endmodule
